// File: rtl/iq_sweep_scheduler.sv
// Frequency-sweep sequencer for one IQ demodulator channel: retunes the NCO, waits for the
// low-pass filter to settle, averages 2^AVG_LOG2 I/Q samples and emits one result per point.
module iq_sweep_scheduler #(
    parameter int AVG_LOG2      = 4,
    parameter int SETTLE_CYCLES = 2048,
    parameter int IDX_W         = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      startInc_i,
    input  logic [31:0]      stepInc_i,
    input  logic [IDX_W-1:0] numPoints_i,
    output logic [31:0]      phaseInc_o,
    input  logic             sampleValid_i,
    input  logic [13:0]      iIn_i,
    input  logic [13:0]      qIn_i,
    output logic [13:0]      resI_o,
    output logic [13:0]      resQ_o,
    output logic [31:0]      resInc_o,
    output logic [IDX_W-1:0] resIndex_o,
    output logic             resValid_o,
    input  logic             resReady_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int ACC_W = 14 + AVG_LOG2;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, EMIT, FINISH} state_e;

    state_e                   state_q, state_d;
    logic [31:0]              phaseInc_q, phaseInc_d;
    logic [31:0]              stepInc_q, stepInc_d;
    logic [IDX_W-1:0]         numPoints_q, numPoints_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [SET_W-1:0]         settleCnt_q, settleCnt_d;
    logic [AVG_LOG2-1:0]      sampleCnt_q, sampleCnt_d;
    logic signed [ACC_W-1:0]  accI_q, accI_d;
    logic signed [ACC_W-1:0]  accQ_q, accQ_d;
    logic [13:0]              resI_q, resI_d;
    logic [13:0]              resQ_q, resQ_d;
    logic [31:0]              resInc_q, resInc_d;
    logic [IDX_W-1:0]         resIndex_q, resIndex_d;
    logic                     resValid_q, resValid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic signed [ACC_W-1:0]  accSumI, accSumQ;
    logic signed [ACC_W-1:0]  shiftI, shiftQ;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            phaseInc_q  <= '0;
            stepInc_q   <= '0;
            numPoints_q <= '0;
            idx_q       <= '0;
            settleCnt_q <= '0;
            sampleCnt_q <= '0;
            accI_q      <= '0;
            accQ_q      <= '0;
            resI_q      <= '0;
            resQ_q      <= '0;
            resInc_q    <= '0;
            resIndex_q  <= '0;
            resValid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phaseInc_q  <= phaseInc_d;
            stepInc_q   <= stepInc_d;
            numPoints_q <= numPoints_d;
            idx_q       <= idx_d;
            settleCnt_q <= settleCnt_d;
            sampleCnt_q <= sampleCnt_d;
            accI_q      <= accI_d;
            accQ_q      <= accQ_d;
            resI_q      <= resI_d;
            resQ_q      <= resQ_d;
            resInc_q    <= resInc_d;
            resIndex_q  <= resIndex_d;
            resValid_q  <= resValid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The final sample is folded in combinationally so the result registers on that same edge.
    always_comb begin
        state_d     = state_q;
        phaseInc_d  = phaseInc_q;
        stepInc_d   = stepInc_q;
        numPoints_d = numPoints_q;
        idx_d       = idx_q;
        settleCnt_d = settleCnt_q;
        sampleCnt_d = sampleCnt_q;
        accI_d      = accI_q;
        accQ_d      = accQ_q;
        resI_d      = resI_q;
        resQ_d      = resQ_q;
        resInc_d    = resInc_q;
        resIndex_d  = resIndex_q;
        resValid_d  = resValid_q;
        busy_d      = (state_q != IDLE);
        done_d      = 1'b0;

        accSumI = accI_q + {{AVG_LOG2{iIn_i[13]}}, iIn_i};
        accSumQ = accQ_q + {{AVG_LOG2{qIn_i[13]}}, qIn_i};
        shiftI  = accSumI >>> AVG_LOG2;
        shiftQ  = accSumQ >>> AVG_LOG2;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (numPoints_i != '0) begin
                        numPoints_d = numPoints_i;
                        stepInc_d   = stepInc_i;
                        phaseInc_d  = startInc_i;
                        idx_d       = '0;
                        settleCnt_d = '0;
                        state_d     = SETTLE;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            SETTLE: begin
                if (settleCnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    accI_d      = '0;
                    accQ_d      = '0;
                    sampleCnt_d = '0;
                    state_d     = ACCUM;
                end else begin
                    settleCnt_d = settleCnt_q + 1'b1;
                end
            end
            ACCUM: begin
                if (sampleValid_i) begin
                    accI_d      = accSumI;
                    accQ_d      = accSumQ;
                    sampleCnt_d = sampleCnt_q + 1'b1;
                    if (sampleCnt_q == '1) begin
                        resI_d     = 14'(shiftI);
                        resQ_d     = 14'(shiftQ);
                        resInc_d   = phaseInc_q;
                        resIndex_d = idx_q;
                        resValid_d = 1'b1;
                        state_d    = EMIT;
                    end
                end
            end
            EMIT: begin
                if (resValid_q && resReady_i) begin
                    resValid_d = 1'b0;
                    if (idx_q == numPoints_q - IDX_W'(1)) begin
                        state_d = FINISH;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        phaseInc_d  = phaseInc_q + stepInc_q;
                        settleCnt_d = '0;
                        state_d     = SETTLE;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything above, including a same-cycle result transfer.
        if (abort_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            resValid_d = 1'b0;
            done_d     = 1'b0;
            phaseInc_d = phaseInc_q;
            idx_d      = idx_q;
        end
    end

    assign phaseInc_o = phaseInc_q;
    assign resI_o     = resI_q;
    assign resQ_o     = resQ_q;
    assign resInc_o   = resInc_q;
    assign resIndex_o = resIndex_q;
    assign resValid_o = resValid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_iq_sweep_scheduler.sv
// Self-checking bench for iq_sweep_scheduler: a table of full sweeps with hand-computed
// averages and phase increments, plus directed sequences for backpressure, abort and reset.
module tb_iq_sweep_scheduler;

    localparam int AVG_LOG2      = 2;
    localparam int SETTLE_CYCLES = 4;
    localparam int IDX_W         = 16;
    localparam int POINT_CYCLES  = SETTLE_CYCLES + (1 << AVG_LOG2) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      startInc = '0;
    logic [31:0]      stepInc = '0;
    logic [IDX_W-1:0] numPoints = '0;
    logic [31:0]      phaseInc;
    logic             sampleValid = 1'b0;
    logic [13:0]      iIn = '0;
    logic [13:0]      qIn = '0;
    logic [13:0]      resI, resQ;
    logic [31:0]      resInc;
    logic [IDX_W-1:0] resIndex;
    logic             resValid;
    logic             resReady = 1'b0;
    logic             busy, done;

    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               pIdx = 0;
    logic             gapMode = 1'b0;
    logic [3:0][13:0] patI = '0;
    logic [3:0][13:0] patQ = '0;

    typedef struct {
        logic [31:0]      startInc;
        logic [31:0]      stepInc;
        logic [15:0]      numPoints;
        logic [3:0][13:0] iPat;
        logic [3:0][13:0] qPat;
        logic [13:0]      expI;
        logic [13:0]      expQ;
        logic [2:0][31:0] expInc;
    } vec_t;

    vec_t vecs[5];

    iq_sweep_scheduler #(
        .AVG_LOG2     (AVG_LOG2),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .IDX_W        (IDX_W)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .abort_i      (abort),
        .startInc_i   (startInc),
        .stepInc_i    (stepInc),
        .numPoints_i  (numPoints),
        .phaseInc_o   (phaseInc),
        .sampleValid_i(sampleValid),
        .iIn_i        (iIn),
        .qIn_i        (qIn),
        .resI_o       (resI),
        .resQ_o       (resQ),
        .resInc_o     (resInc),
        .resIndex_o   (resIndex),
        .resValid_o   (resValid),
        .resReady_i   (resReady),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // The sample pattern advances only on consumed valid samples, so any four consecutive
    // valid samples sum to the same value regardless of where accumulation starts.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sampleValid) pIdx = (pIdx + 1) % 4;
        cyc++;
        sampleValid = gapMode ? cyc[0] : 1'b1;
        iIn = sampleValid ? patI[pIdx] : 14'h2000;
        qIn = sampleValid ? patQ[pIdx] : 14'h1FFF;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (resValid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (resValid !== 1'b1) checkOutput("validTimeout", resValid, 32'd1);
    endtask

    task automatic applyStimulus(input int v);
        vec_t t = vecs[v];
        int   n;
        patI = t.iPat;
        patQ = t.qPat;
        gapMode = 1'b0;
        resReady = 1'b1;
        sampleValid = 1'b1;
        pIdx = 0;
        iIn = patI[0];
        qIn = patQ[0];
        startInc = t.startInc;
        stepInc = t.stepInc;
        numPoints = t.numPoints;
        start = 1'b1;
        tick();
        start = 1'b0;
        startInc = 32'hDEADBEEF;
        stepInc = 32'h1;
        numPoints = 16'd9;
        for (int k = 0; k < int'(t.numPoints); k++) begin
            if (k > 0) tick();
            waitValid(n);
            checkOutput($sformatf("v%0d.p%0d.latency", v, k), 32'(n + 1), POINT_CYCLES);
            checkOutput($sformatf("v%0d.p%0d.resI", v, k), resI, t.expI);
            checkOutput($sformatf("v%0d.p%0d.resQ", v, k), resQ, t.expQ);
            checkOutput($sformatf("v%0d.p%0d.resInc", v, k), resInc, t.expInc[k]);
            checkOutput($sformatf("v%0d.p%0d.phaseInc", v, k), phaseInc, t.expInc[k]);
            checkOutput($sformatf("v%0d.p%0d.resIndex", v, k), resIndex, 32'(k));
            checkOutput($sformatf("v%0d.p%0d.busy", v, k), busy, 32'd1);
        end
        tick();
        checkOutput($sformatf("v%0d.validDrop", v), resValid, 32'd0);
        checkOutput($sformatf("v%0d.doneEarly", v), done, 32'd0);
        tick();
        checkOutput($sformatf("v%0d.done", v), done, 32'd1);
        tick();
        checkOutput($sformatf("v%0d.doneOnce", v), done, 32'd0);
        checkOutput($sformatf("v%0d.idleBusy", v), busy, 32'd0);
        checkOutput($sformatf("v%0d.lastPhase", v), phaseInc, t.expInc[int'(t.numPoints) - 1]);
    endtask

    initial begin
        int   n;
        logic flag;

        vecs[0] = '{startInc: 32'd100, stepInc: 32'd10, numPoints: 16'd3,
                    iPat: {4{14'd8}}, qPat: {4{14'd8}}, expI: 14'd8, expQ: 14'd8,
                    expInc: {32'd120, 32'd110, 32'd100}};
        vecs[1] = '{startInc: 32'd5, stepInc: 32'd7, numPoints: 16'd1,
                    iPat: {14'h3FFD, 14'h3FFE, 14'h3FFE, 14'h3FFE}, qPat: {4{14'h1FFF}},
                    expI: 14'h3FFD, expQ: 14'h1FFF, expInc: {32'd0, 32'd0, 32'd5}};
        vecs[2] = '{startInc: 32'hFFFFFFF0, stepInc: 32'h20, numPoints: 16'd2,
                    iPat: {14'd1, 14'd2, 14'd3, 14'd4}, qPat: {4{14'h3FFF}},
                    expI: 14'd2, expQ: 14'h3FFF, expInc: {32'd0, 32'h00000010, 32'hFFFFFFF0}};
        vecs[3] = '{startInc: 32'd0, stepInc: 32'h80000000, numPoints: 16'd2,
                    iPat: {4{14'h2000}}, qPat: {14'd5, 14'd0, 14'd0, 14'd0},
                    expI: 14'h2000, expQ: 14'd1, expInc: {32'd0, 32'h80000000, 32'd0}};
        vecs[4] = '{startInc: 32'h12345678, stepInc: 32'd0, numPoints: 16'd1,
                    iPat: {14'h3FFF, 14'd0, 14'd0, 14'd0}, qPat: {14'd3, 14'd0, 14'd0, 14'd0},
                    expI: 14'h3FFF, expQ: 14'd0, expInc: {32'd0, 32'd0, 32'h12345678}};

        reset = 1'b1;
        repeat (3) tick();
        checkOutput("rst.phaseInc", phaseInc, 32'd0);
        checkOutput("rst.resI", resI, 32'd0);
        checkOutput("rst.resQ", resQ, 32'd0);
        checkOutput("rst.resInc", resInc, 32'd0);
        checkOutput("rst.resIndex", resIndex, 32'd0);
        checkOutput("rst.resValid", resValid, 32'd0);
        checkOutput("rst.busy", busy, 32'd0);
        checkOutput("rst.done", done, 32'd0);
        reset = 1'b0;
        tick();

        // Empty sweep: straight to FINISH, done two cycles after start.
        numPoints = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("zero.busyC1", busy, 32'd0);
        checkOutput("zero.doneC1", done, 32'd0);
        tick();
        checkOutput("zero.busyC2", busy, 32'd1);
        checkOutput("zero.doneC2", done, 32'd1);
        checkOutput("zero.resValid", resValid, 32'd0);
        tick();
        checkOutput("zero.busyC3", busy, 32'd0);
        checkOutput("zero.doneC3", done, 32'd0);

        for (int v = 0; v < 5; v++) applyStimulus(v);

        // Backpressure in EMIT with gapped samples carrying junk on invalid cycles.
        patI = {4{14'd8}};
        patQ = {4{14'h3FFB}};
        gapMode = 1'b1;
        resReady = 1'b0;
        startInc = 32'd500;
        stepInc = 32'd25;
        numPoints = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitValid(n);
        checkOutput("bp.resI", resI, 32'd8);
        checkOutput("bp.resQ", resQ, 32'h3FFB);
        checkOutput("bp.resInc", resInc, 32'd500);
        gapMode = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (resValid !== 1'b1 || resI !== 14'd8 || resQ !== 14'h3FFB || resInc !== 32'd500 ||
                resIndex !== 16'd0 || phaseInc !== 32'd500) flag = 1'b1;
        end
        checkOutput("bp.holdStable", flag, 32'd0);
        resReady = 1'b1;
        tick();
        checkOutput("bp.validDrop", resValid, 32'd0);
        checkOutput("bp.nextPhase", phaseInc, 32'd525);
        waitValid(n);
        checkOutput("bp.nextLatency", 32'(n + 1), POINT_CYCLES);
        checkOutput("bp.nextResInc", resInc, 32'd525);
        checkOutput("bp.nextIndex", resIndex, 32'd1);
        tick();
        tick();
        checkOutput("bp.done", done, 32'd1);
        tick();

        // Abort while accumulating.
        patI = {4{14'd8}};
        patQ = {4{14'd8}};
        startInc = 32'd700;
        stepInc = 32'd3;
        numPoints = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checkOutput("abAcc.busyBefore", busy, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abAcc.resValid", resValid, 32'd0);
        checkOutput("abAcc.phaseHeld", phaseInc, 32'd700);
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done !== 1'b0 || resValid !== 1'b0) flag = 1'b1;
        end
        checkOutput("abAcc.noDone", flag, 32'd0);
        checkOutput("abAcc.idle", busy, 32'd0);

        // Abort together with a handshake in EMIT: abort must win.
        resReady = 1'b0;
        startInc = 32'd1000;
        stepInc = 32'd1;
        numPoints = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitValid(n);
        abort = 1'b1;
        resReady = 1'b1;
        tick();
        abort = 1'b0;
        resReady = 1'b0;
        checkOutput("abEmit.resValid", resValid, 32'd0);
        checkOutput("abEmit.phaseHeld", phaseInc, 32'd1000);
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done !== 1'b0 || resValid !== 1'b0) flag = 1'b1;
        end
        checkOutput("abEmit.noDone", flag, 32'd0);
        checkOutput("abEmit.idle", busy, 32'd0);

        applyStimulus(0);

        // Reset in the middle of a sweep while a second-point result is pending.
        patI = {4{14'd8}};
        patQ = {4{14'd8}};
        resReady = 1'b1;
        startInc = 32'h55;
        stepInc = 32'h11;
        numPoints = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitValid(n);
        tick();
        resReady = 1'b0;
        waitValid(n);
        checkOutput("midRst.preIndex", resIndex, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midRst.phaseInc", phaseInc, 32'd0);
        checkOutput("midRst.resI", resI, 32'd0);
        checkOutput("midRst.resQ", resQ, 32'd0);
        checkOutput("midRst.resInc", resInc, 32'd0);
        checkOutput("midRst.resIndex", resIndex, 32'd0);
        checkOutput("midRst.resValid", resValid, 32'd0);
        checkOutput("midRst.busy", busy, 32'd0);
        checkOutput("midRst.done", done, 32'd0);
        tick();
        checkOutput("midRst.idle", busy, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
